// File: rtl/xsimbus_rr_arbiter.sv
// xSimBus master-side round-robin arbiter: one owner at a time, hold timeout
// with per-master lock override, one turnaround cycle between owners.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | no owner, waiting for any request
// S_GRANT   | bus owned by r_master_id, hold counter running
// S_RELEASE | turnaround cycle, grant low, next winner picked on exit
module xsimbus_rr_arbiter #(
    parameter int NUM_MASTERS = 32,
    parameter int ID_W        = 5,
    parameter int MAX_HOLD    = 256,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_in,
    input  logic [NUM_MASTERS-1:0] lock_in,
    output logic [NUM_MASTERS-1:0] grant_out,
    output logic [ID_W-1:0]        master_id_out,
    output logic                   busy_out,
    output logic                   timeout_out,
    output logic [ID_W-1:0]        timeout_id_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic             L_TO_EN   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] L_HOLD    = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] L_HOLD_M1 = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]  L_LAST_RST = ID_W'(NUM_MASTERS - 1);
    localparam logic [ID_W:0]    L_NUM      = (ID_W + 1)'(NUM_MASTERS);

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [ID_W-1:0]        r_master_id;
    logic [ID_W-1:0]        r_last_id;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_timeout;
    logic [ID_W-1:0]        r_timeout_id;

    logic [ID_W:0]          w_scan;
    logic [ID_W-1:0]        w_winner;
    logic                   w_found;
    logic [NUM_MASTERS-1:0] w_onehot;
    logic                   w_owner_req;
    logic                   w_owner_lock;
    logic                   w_cnt_sat;
    logic                   w_timeout_hit;

    // Scan from farthest to nearest so the last hit is the first slot after r_last_id.
    always_comb begin
        w_scan   = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_scan = {1'b0, r_last_id} + (ID_W + 1)'(k);
            if (w_scan >= L_NUM) begin
                w_scan = w_scan - L_NUM;
            end
            if (req_in[w_scan]) begin
                w_found  = 1'b1;
                w_winner = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_onehot      = NUM_MASTERS'(1) << w_winner;
    assign w_owner_req   = req_in[r_master_id];
    assign w_owner_lock  = lock_in[r_master_id];
    assign w_cnt_sat     = (r_cnt == L_HOLD);
    // >= rather than == so a lock released after saturation still revokes.
    assign w_timeout_hit = L_TO_EN && (r_cnt >= L_HOLD_M1) && !w_owner_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_master_id  <= '0;
            r_last_id    <= L_LAST_RST;
            r_cnt        <= '0;
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE, S_RELEASE: begin
                    if (w_found) begin
                        r_state     <= S_GRANT;
                        r_grant     <= w_onehot;
                        r_master_id <= w_winner;
                        r_last_id   <= w_winner;
                        r_cnt       <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GRANT: begin
                    if (!w_owner_req) begin
                        r_state <= S_RELEASE;
                        r_grant <= '0;
                    end else if (w_timeout_hit) begin
                        r_state      <= S_RELEASE;
                        r_grant      <= '0;
                        r_timeout    <= 1'b1;
                        r_timeout_id <= r_master_id;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant_out      = r_grant;
    assign master_id_out  = r_master_id;
    assign busy_out       = (r_state == S_GRANT);
    assign timeout_out    = r_timeout;
    assign timeout_id_out = r_timeout_id;

endmodule

// File: tb/tb_xsimbus_rr_arbiter.sv
// Bench for xsimbus_rr_arbiter: directed scenarios plus a randomized run,
// all compared cycle by cycle against an owner/queue-level reference model.
module tb_xsimbus_rr_arbiter;

    localparam int N    = 32;
    localparam int IDW  = 5;
    localparam int HOLD = 4;
    localparam int CW   = 16;
    localparam int VW   = N + 2 * IDW + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_in = '0;
    logic [N-1:0]   lock_in = '0;
    logic [N-1:0]   grant_out;
    logic [IDW-1:0] master_id_out;
    logic           busy_out;
    logic           timeout_out;
    logic [IDW-1:0] timeout_id_out;
    logic [VW-1:0]  obs;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus, how long it has held, last winner.
    int m_owner;
    int m_last;
    int m_id;
    int m_held;
    int m_to_id;
    bit m_to;

    always #5 clk = ~clk;

    xsimbus_rr_arbiter #(
        .NUM_MASTERS(N), .ID_W(IDW), .MAX_HOLD(HOLD), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .lock_in(lock_in),
        .grant_out(grant_out), .master_id_out(master_id_out), .busy_out(busy_out),
        .timeout_out(timeout_out), .timeout_id_out(timeout_id_out)
    );

    assign obs = {grant_out, busy_out, master_id_out, timeout_out, timeout_id_out};

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return {g, (m_owner >= 0), m_id[IDW-1:0], m_to, m_to_id[IDW-1:0]};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_id    = 0;
        m_held  = 0;
        m_to    = 0;
        m_to_id = 0;
    endtask

    // Without an owner (idle or turnaround) the next edge hands the bus to the RR winner.
    task automatic model_update(input logic [N-1:0] req, input logic [N-1:0] lock);
        int w;
        m_to = 0;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
            end else if (m_held >= HOLD - 1 && !lock[m_owner]) begin
                m_to    = 1;
                m_to_id = m_owner;
                m_owner = -1;
            end else if (m_held < HOLD) begin
                m_held++;
            end
        end else begin
            w = rr_pick(req, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_id    = w;
                m_held  = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(req_in, lock_in);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_in = '0;
        lock_in = '0;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        rst = 1'b0;
        step();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        req_in = 32'h0000_0001;
        step();
        checks++;
        if (grant_out !== 32'h1 || master_id_out !== 5'd0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got=%h/%0d/%b want=1/0/1", grant_out, master_id_out, busy_out);
        end
        req_in = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_release c=%0d got=%h want=%h", c, obs, exp_vec());
            end
            checks++;
            if (grant_out !== '0 || busy_out !== 1'b0) begin
                errors++;
                $display("FAIL single_quiet c=%0d got=%h/%b want=0/0", c, grant_out, busy_out);
            end
        end
    endtask

    task automatic test_rr_order();
        int ids[$];
        int exp_ids[4] = '{0, 29, 31, 0};
        int gap;
        logic [N-1:0] prev_g;
        logic [N-1:0] base;
        do_reset();
        base = 32'hA000_0001;
        gap = 0;
        prev_g = '0;
        req_in = base;
        for (int c = 0; c < 60 && ids.size() < 4; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rr_model c=%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (grant_out != '0 && prev_g == '0) begin
                if (ids.size() > 0) begin
                    checks++;
                    if (gap !== 1) begin
                        errors++;
                        $display("FAIL rr_gap got=%0d want=1", gap);
                    end
                end
                ids.push_back(int'(master_id_out));
                gap = 0;
            end else if (grant_out == '0) begin
                gap++;
            end
            prev_g = grant_out;
            req_in = (m_owner >= 0 && m_held == 2) ? (base & ~(N'(1) << m_owner)) : base;
        end
        checks++;
        if (ids.size() != 4) begin
            errors++;
            $display("FAIL rr_count got=%0d want=4", ids.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ids[k] !== exp_ids[k]) begin
                    errors++;
                    $display("FAIL rr_order k=%0d got=%0d want=%0d", k, ids[k], exp_ids[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int busy29;
        bit seen;
        do_reset();
        req_in = N'(1) << 29;
        step();
        busy29 = (busy_out && master_id_out == 5'd29) ? 1 : 0;
        seen = 0;
        req_in = (N'(1) << 29) | (N'(1) << 31);
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL to_model c=%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (busy_out && master_id_out == 5'd29) busy29++;
            if (timeout_out) begin
                seen = 1;
                checks++;
                if (timeout_id_out !== 5'd29) begin
                    errors++;
                    $display("FAIL to_id got=%0d want=29", timeout_id_out);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL to_pulse got=none want=pulse");
        end
        checks++;
        if (busy29 !== HOLD) begin
            errors++;
            $display("FAIL to_busy_len got=%0d want=%0d", busy29, HOLD);
        end
        step();
        checks++;
        if (grant_out !== (N'(1) << 31) || master_id_out !== 5'd31 || timeout_out !== 1'b0) begin
            errors++;
            $display("FAIL to_next_owner got=%h/%0d want=%h/31", grant_out, master_id_out, N'(1) << 31);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req_in = N'(1) << 29;
        step();
        req_in = (N'(1) << 29) | (N'(1) << 31);
        lock_in = N'(1) << 29;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (timeout_out !== 1'b0 || busy_out !== 1'b1 || master_id_out !== 5'd29) begin
                errors++;
                $display("FAIL lock_hold c=%0d got=to%b/busy%b/id%0d want=to0/busy1/id29",
                         c, timeout_out, busy_out, master_id_out);
            end
        end
        lock_in = '0;
        step();
        checks++;
        if (timeout_out !== 1'b1 || timeout_id_out !== 5'd29 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL lock_release got=to%b/id%0d/busy%b want=to1/id29/busy0",
                     timeout_out, timeout_id_out, busy_out);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL lock_model got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_drop_at_limit();
        req_in = '0;
        lock_in = '0;
        for (int c = 0; c < 3; c++) step();
        req_in = N'(1) << 5;
        step();
        for (int c = 0; c < HOLD - 1; c++) begin
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL drop_model c=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
        req_in = '0;
        step();
        checks++;
        if (timeout_out !== 1'b0 || timeout_id_out !== 5'd29 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL drop_wins got=to%b/id%0d/busy%b want=to0/id29/busy0",
                     timeout_out, timeout_id_out, busy_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_in = N'(1) << 7;
        step();
        step();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (grant_out !== '0 || busy_out !== 1'b0 || master_id_out !== '0 || timeout_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%h want=0", obs);
        end
        model_reset();
        #2;
        rst = 1'b0;
        req_in = 32'h8000_0001;
        step();
        checks++;
        if (grant_out !== 32'h1 || master_id_out !== 5'd0) begin
            errors++;
            $display("FAIL ptr_reset got=%h/%0d want=1/0", grant_out, master_id_out);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) req_in = $urandom() & $urandom();
            if (m_owner >= 0 && $urandom_range(0, 5) == 0) req_in[m_owner] = 1'b0;
            if ($urandom_range(0, 3) == 0) lock_in = $urandom() & $urandom();
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL rand_model c=%0d got=%h want=%h", c, obs, exp_vec());
            end
            checks++;
            if ((grant_out & (grant_out - 1'b1)) != '0 || busy_out !== (|grant_out)) begin
                errors++;
                $display("FAIL rand_invariant c=%0d got=%h/%b want=onehot/busy", c, grant_out, busy_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_timeout();
        test_lock();
        test_drop_at_limit();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xsimbus_rr_arbiter.md
Name: xsimbus_rr_arbiter

Overview:
Round-robin bus arbiter for the xSimBus master side. It accepts one request bit per bus device slot and grants the bus to exactly one master at a time. It holds each grant until the owner drops its request or a hold timeout expires, and inserts one turnaround cycle between owners. Its outputs drive the master-ID select and the bus hold flag that the core and peripherals consume.

Parameters:
NUM_MASTERS, 32, number of request slots (device IDs 0..NUM_MASTERS-1); legal range 2..32.
ID_W, 5, width of master ID; must satisfy 2^ID_W >= NUM_MASTERS.
MAX_HOLD, 256, maximum consecutive GRANT cycles before forced release; 0 disables the timeout.
CNT_W, 16, hold-counter width; must hold MAX_HOLD.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  asynchronous, active-high reset.
req_in  in  NUM_MASTERS  per-master bus request; bit i = device i.
lock_in  in  NUM_MASTERS  per-master lock; when the owner's bit is high, the timeout is suppressed.
grant_out  out  NUM_MASTERS  registered one-hot grant; all zero when no owner.
master_id_out  out  ID_W  ID of the current owner; valid only while busy_out=1.
busy_out  out  1  bus hold flag; 1 exactly while state=GRANT.
timeout_out  out  1  single-cycle pulse when a grant is forcibly revoked.
timeout_id_out  out  ID_W  ID of the last revoked owner; holds its value until the next timeout.

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer):
  - state=IDLE, grant_out=0, master_id_out=0, busy_out=0.
  - timeout_out=0, timeout_id_out=0, hold counter=0.
  - RR pointer last_id=NUM_MASTERS-1, so device 0 has top priority first.
- Round-robin search: the winner is the first i with req_in[i]=1 scanning last_id+1, last_id+2, ..., wrapping modulo NUM_MASTERS. last_id itself is scanned last. The search is combinational from registered last_id and live req_in.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - No requests: stay in IDLE, all outputs quiet.
  - Any request: next edge goes to GRANT. grant_out=onehot(winner), master_id_out=winner, last_id=winner, counter=0. Request-to-grant latency is 1 cycle.
- GRANT:
  - req_in[owner]=1: stay in GRANT; counter increments, saturating at MAX_HOLD.
  - req_in[owner]=0: next edge goes to RELEASE; grant_out=0, busy_out=0.
  - Timeout: MAX_HOLD!=0, counter==MAX_HOLD-1, req_in[owner]=1, lock_in[owner]=0. Next edge goes to RELEASE, timeout_out=1 for that one cycle, timeout_id_out=owner. A revoked owner competes again normally and is scanned last.
  - lock_in[owner]=1: the counter still saturates, but no timeout fires. If lock drops while the counter is already saturated, the timeout fires on the next edge.
  - Changes to other requesters' req_in do not affect the current grant (no preemption).
- RELEASE: one turnaround cycle with grant_out=0. On the next edge:
  - Requests pending: go directly to GRANT with a fresh RR winner.
  - No requests: go to IDLE.
- Simultaneous events:
  - Owner drop and timeout on the same edge: the drop wins and timeout_out stays 0.
  - Owner re-raising req_in during RELEASE: treated as a fresh request under RR.
- Invariants:
  - grant_out is always zero or one-hot.
  - busy_out == |grant_out.
  - master_id_out is unchanged outside GRANT entry.
- Width rules:
  - The pointer increment wraps modulo NUM_MASTERS, not 2^ID_W.
  - req_in bits at or above NUM_MASTERS do not exist.

Test Plan:
1. Reset then req_in=0x0000_0001 → 1 cycle later grant_out=0x1, master_id_out=0, busy_out=1. Drop req → next cycle grant 0 (RELEASE), then IDLE.
2. req_in=0xA000_0001 (devices 0, 29, 31) held continuously with owners dropping after 3 cycles each → grant order 0, 29, 31, 0. Exactly 1 zero-grant cycle between owners.
3. MAX_HOLD=4, device 29 holds req with lock low → busy for 4 cycles, then timeout_out=1 one cycle, timeout_id_out=29. With device 31 also requesting, the next grant goes to 31.
4. Same as 3 but lock_in[29]=1 for 10 cycles, then lock dropped → no timeout during the lock. Timeout pulse on the edge after lock drops.
5. Assert rst asynchronously mid-GRANT (between clock edges) → grant_out, busy_out, master_id_out go 0 immediately. After release, req_in=0x8000_0001 grants device 0 first (pointer reset).
6. Device 5 owner drops req on the same edge its counter reaches MAX_HOLD-1 → RELEASE with timeout_out=0, and timeout_id_out unchanged.
